// File: rtl/fifo_pkg.sv
// Shared sizing helpers and modulo-DEPTH pointer arithmetic for the multi-port FIFO.
package fifo_pkg;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Valid for a < depth and b <= depth: one conditional subtraction wraps the sum.
    function automatic int unsigned mod_add(input int unsigned a, input int unsigned b,
                                            input int unsigned depth);
        int unsigned s;
        s = a + b;
        return (s >= depth) ? s - depth : s;
    endfunction

endpackage

// File: rtl/fifo_storage.sv
// Element array with a PAR_WRITE-wide write port and a PAR_READ-wide asynchronous read port.
module fifo_storage
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned PAR_WRITE  = 2,
    parameter int unsigned PAR_READ   = 2
) (
    input  logic                               clk_i,
    input  logic                               we_i,
    input  logic [ptr_width(DEPTH)-1:0]        waddr_i,
    input  logic [PAR_WRITE*DATA_WIDTH-1:0]    wdata_i,
    input  logic [ptr_width(DEPTH)-1:0]        raddr_i,
    output logic [PAR_READ*DATA_WIDTH-1:0]     rdata_o
);

    localparam int unsigned PtrW = ptr_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]       waddr [PAR_WRITE];
    logic [PtrW-1:0]       raddr [PAR_READ];

    always_comb begin
        for (int unsigned i = 0; i < PAR_WRITE; i++) begin
            waddr[i] = PtrW'(mod_add(32'(waddr_i), i, DEPTH));
        end
        for (int unsigned j = 0; j < PAR_READ; j++) begin
            raddr[j] = PtrW'(mod_add(32'(raddr_i), j, DEPTH));
        end
    end

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int unsigned i = 0; i < PAR_WRITE; i++) begin
                mem_q[waddr[i]] <= wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int unsigned j = 0; j < PAR_READ; j++) begin
            rdata_o[j*DATA_WIDTH +: DATA_WIDTH] = mem_q[raddr[j]];
        end
    end

endmodule

// File: rtl/multi_port_fifo.sv
// First-word-fall-through FIFO moving PAR_WRITE elements in and PAR_READ elements out per beat.
// Status flags decode the occupancy count only; overflow/underflow are sticky until clear/rst.
module multi_port_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned PAR_WRITE  = 2,
    parameter int unsigned PAR_READ   = 2,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AF_LEVEL   = DEPTH - PAR_WRITE,
    parameter int unsigned AE_LEVEL   = PAR_READ
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic                            wen,
    input  logic [PAR_WRITE*DATA_WIDTH-1:0] din,
    input  logic                            ren,
    output logic [PAR_READ*DATA_WIDTH-1:0]  dout,
    output logic                            full,
    output logic                            empty,
    output logic                            almost_full,
    output logic                            almost_empty,
    output logic [cnt_width(DEPTH)-1:0]     count,
    output logic                            overflow,
    output logic                            underflow
);

    localparam int unsigned PtrW = ptr_width(DEPTH);
    localparam int unsigned CntW = cnt_width(DEPTH);

    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            underflow_q, underflow_d;
    logic            wr_acc, rd_acc;

    always_comb begin
        full         = 32'(count_q) > (DEPTH - PAR_WRITE);
        empty        = 32'(count_q) < PAR_READ;
        almost_full  = 32'(count_q) >= AF_LEVEL;
        almost_empty = 32'(count_q) <= AE_LEVEL;
        wr_acc       = wen && !full;
        rd_acc       = ren && !empty;
    end

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear) begin
            wptr_d      = '0;
            rptr_d      = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) begin
                wptr_d = PtrW'(mod_add(32'(wptr_q), PAR_WRITE, DEPTH));
            end
            if (rd_acc) begin
                rptr_d = PtrW'(mod_add(32'(rptr_q), PAR_READ, DEPTH));
            end
            count_d = CntW'(32'(count_q) + (wr_acc ? PAR_WRITE : 32'd0)
                                         - (rd_acc ? PAR_READ : 32'd0));
            if (wen && full) begin
                overflow_d = 1'b1;
            end
            if (ren && empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    fifo_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PAR_WRITE  (PAR_WRITE),
        .PAR_READ   (PAR_READ)
    ) u_storage (
        .clk_i   (clk),
        .we_i    (wr_acc && !clear && !rst),
        .waddr_i (wptr_q),
        .wdata_i (din),
        .raddr_i (rptr_q),
        .rdata_o (dout)
    );

endmodule

// File: tb/tb_multi_port_fifo.sv
// Directed bench for multi_port_fifo (W=2, R=3, DEPTH=7): scoreboard queue checked by a monitor.
module tb_multi_port_fifo;

    logic        clk = 1'b0;
    logic        rst, clear, wen, ren;
    logic [31:0] din;
    logic [47:0] dout;
    logic        full, empty, almost_full, almost_empty, overflow, underflow;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;

    logic [47:0] exp_q [$];
    logic [15:0] model_q [$];
    int          m_cnt = 0;
    logic        m_ovf = 1'b0;
    logic        m_udf = 1'b0;

    always #5 clk = ~clk;

    multi_port_fifo #(
        .DATA_WIDTH (16),
        .PAR_WRITE  (2),
        .PAR_READ   (3),
        .DEPTH      (7),
        .AF_LEVEL   (5),
        .AE_LEVEL   (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .wen          (wen),
        .din          (din),
        .ren          (ren),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Drive one beat just after a clock edge, update the reference model, advance one cycle.
    task automatic step(input logic w, input logic [31:0] d, input logic r);
        logic w_ok, r_ok;
        wen = w;
        din = d;
        ren = r;
        if (rst || clear) begin
            model_q.delete();
            m_cnt = 0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            w_ok = w && (m_cnt <= 5);
            r_ok = r && (m_cnt >= 3);
            if (r_ok) begin
                exp_q.push_back({model_q[2], model_q[1], model_q[0]});
                repeat (3) void'(model_q.pop_front());
            end
            if (w_ok) begin
                model_q.push_back(d[15:0]);
                model_q.push_back(d[31:16]);
            end
            m_cnt = m_cnt + (w_ok ? 2 : 0) - (r_ok ? 3 : 0);
            if (w && !w_ok) m_ovf = 1'b1;
            if (r && !r_ok) m_udf = 1'b1;
        end
        @(posedge clk);
        #1;
        wen = 1'b0;
        ren = 1'b0;
        din = '0;
    endtask

    // Monitor: every accepted read must match the oldest expected word.
    initial begin
        logic [47:0] e;
        forever begin
            @(negedge clk);
            if (!rst && !clear && ren && !empty) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL read_unexpected actual=%0h required=none", dout);
                end else begin
                    e = exp_q.pop_front();
                    if (dout !== e) begin
                        failures++;
                        $display("FAIL read_data actual=%0h required=%0h", dout, e);
                    end
                end
            end
        end
    end

    initial begin
        logic [19:0] wpat, rpat;
        logic [15:0] val;
        rst   = 1'b1;
        clear = 1'b0;
        wen   = 1'b0;
        ren   = 1'b0;
        din   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_aempty", almost_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_udf", underflow, 0);

        step(1'b1, 32'h0002_0001, 1'b0);
        step(1'b1, 32'h0004_0003, 1'b0);
        chk("fill_count4", count, 4);
        chk("fill_empty", empty, 0);
        chk("fill_aempty", almost_empty, 0);
        chk("fill_full4", full, 0);
        chk("fwft_dout", dout, 48'h0003_0002_0001);

        step(1'b1, 32'h0006_0005, 1'b0);
        chk("fill_count6", count, 6);
        chk("fill_full6", full, 1);
        chk("fill_afull6", almost_full, 1);
        chk("pre_ovf", overflow, 0);
        step(1'b1, 32'h0008_0007, 1'b0);
        chk("rej_count", count, 6);
        chk("rej_ovf", overflow, 1);
        chk("rej_full", full, 1);

        step(1'b1, 32'h000a_0009, 1'b1);
        chk("rw_full_count", count, 3);
        chk("rw_full_ovf", overflow, 1);

        step(1'b1, 32'h000c_000b, 1'b1);
        chk("rw_both_count", count, 2);
        chk("rw_both_empty", empty, 1);
        chk("rw_both_udf", underflow, 0);
        step(1'b0, 32'h0, 1'b1);
        chk("udf_set", underflow, 1);
        chk("udf_count", count, 2);

        step(1'b1, 32'h000e_000d, 1'b0);
        chk("pre_clr_count", count, 4);
        clear = 1'b1;
        step(1'b1, 32'h0010_000f, 1'b0);
        clear = 1'b0;
        chk("clr_count", count, 0);
        chk("clr_ovf", overflow, 0);
        chk("clr_udf", underflow, 0);
        chk("clr_empty", empty, 1);
        chk("clr_aempty", almost_empty, 1);
        step(1'b1, 32'h0101_0100, 1'b0);
        step(1'b1, 32'h0103_0102, 1'b0);
        chk("post_clr_dout", dout, 48'h0102_0101_0100);
        step(1'b0, 32'h0, 1'b1);
        chk("post_clr_count", count, 1);

        wpat = 20'b1101_1011_0111_0110_1101;
        rpat = 20'b0110_1101_1011_1011_0110;
        val  = 16'h0200;
        for (int i = 0; i < 20; i++) begin
            step(wpat[i], {16'(val + 16'd1), val}, rpat[i]);
            val = 16'(val + 16'd2);
        end
        repeat (3) step(1'b0, 32'h0, 1'b1);
        chk("mix_count", count, 3'(m_cnt));
        chk("mix_ovf", overflow, m_ovf);
        chk("mix_udf", underflow, m_udf);

        step(1'b1, 32'h0301_0300, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        chk("pre_rst_udf", underflow, 1);
        rst   = 1'b1;
        clear = 1'b1;
        step(1'b1, 32'h0303_0302, 1'b0);
        rst   = 1'b0;
        clear = 1'b0;
        chk("rstclr_count", count, 0);
        chk("rstclr_empty", empty, 1);
        chk("rstclr_aempty", almost_empty, 1);
        chk("rstclr_full", full, 0);
        chk("rstclr_afull", almost_full, 0);
        chk("rstclr_ovf", overflow, 0);
        chk("rstclr_udf", underflow, 0);

        chk("scoreboard_drained", 64'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
